// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, port ids and RAM geometry for ram_arbiter_2 and its RAM
package ram_arb_pkg;

    localparam int ADDR_SIZE = 10;
    localparam int WORD_SIZE = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; a lone requester wins, on contention the port not granted last wins
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o[0] = valid_i[0] & (~valid_i[1] | (last_grant_i == PORT1));
        grant_o[1] = valid_i[1] & (~valid_i[0] | (last_grant_i == PORT0));
    end

endmodule

// File: rtl/ram_arbiter_2.sv
// ram_arbiter_2: serialises two valid/ready requesters onto one single-port RAM with registered responses
module ram_arbiter_2
    import ram_arb_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE,
    parameter int word_size = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic                 req0_wr,
    input  logic [addr_size-1:0] req0_addr,
    input  logic [word_size-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [word_size-1:0] rsp0_rdata,
    input  logic                 req1_valid,
    input  logic                 req1_wr,
    input  logic [addr_size-1:0] req1_addr,
    input  logic [word_size-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [word_size-1:0] rsp1_rdata,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_wr,
    output logic                 mem_cs,
    input  logic [word_size-1:0] mem_data_out
);

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [1:0]           grant;
    logic                 accept;
    logic [addr_size-1:0] addr_q;
    logic [word_size-1:0] wdata_q, rdata0_q, rdata1_q;
    logic                 wr_q, port_q, rsp0_q, rsp1_q;

    rr_arbiter_2 u_rr (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        accept       = (state_q == IDLE) && (|grant);
        state_d      = accept ? ACCESS : IDLE;
        last_grant_d = accept ? grant[1] : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp0_q       <= (state_q == ACCESS) && (port_q == PORT0);
            rsp1_q       <= (state_q == ACCESS) && (port_q == PORT1);
        end
    end

    // Hold registers double as the RAM drive, so addr/data_in keep their last value between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            port_q   <= PORT0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= grant[1] ? req1_addr : req0_addr;
                wdata_q <= grant[1] ? req1_wdata : req0_wdata;
                wr_q    <= grant[1] ? req1_wr : req0_wr;
                port_q  <= grant[1];
            end
            if ((state_q == ACCESS) && !wr_q && (port_q == PORT0))
                rdata0_q <= mem_data_out;
            if ((state_q == ACCESS) && !wr_q && (port_q == PORT1))
                rdata1_q <= mem_data_out;
        end
    end

    always_comb begin
        req0_ready  = (state_q == IDLE) && grant[0];
        req1_ready  = (state_q == IDLE) && grant[1];
        mem_cs      = (state_q == ACCESS);
        mem_wr      = (state_q == ACCESS) && wr_q;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        rsp0_valid  = rsp0_q;
        rsp1_valid  = rsp1_q;
        rsp0_rdata  = rdata0_q;
        rsp1_rdata  = rdata1_q;
    end

endmodule

// File: tb/tb_ram_arbiter_2.sv
// tb_ram_arbiter_2: directed vector table, hand sequences and random traffic against a transaction-level model
module tb_ram_arbiter_2;
    import ram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req0_wr = 1'b0, req1_valid = 1'b0, req1_wr = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid, mem_wr, mem_cs;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    ram_arbiter_2 #(.addr_size(AW), .word_size(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_cs(mem_cs),
        .mem_data_out(mem_data_out)
    );

    // RAM stores data xor address, so an untouched word reads back as its own low address bits
    logic [DW-1:0] ram [1<<AW] = '{default: '0};
    assign mem_data_out = ram[mem_addr] ^ mem_addr[DW-1:0];
    always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_data_in ^ mem_addr[DW-1:0];

    int tests = 0;
    int fails = 0;
    int n;
    int acc_at;
    logic acc_port, acc_wr, last, m_acc0, m_acc1;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata, acc_data, exp_rd0, exp_rd1;
    logic [DW-1:0] ref_mem [1<<AW];

    typedef struct {
        logic v0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic r0, r1, cs, wr, rv0, rv1;
        logic chk; logic [DW-1:0] rd0;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic drive(input logic v0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic idle();
        drive(L, L, '0, '0, L, L, '0, '0);
    endtask

    task automatic model_reset();
        n = 0; acc_at = -10; acc_port = 1'b0; acc_wr = 1'b0; acc_data = '0; last = 1'b1;
        last_addr = '0; last_wdata = '0; exp_rd0 = '0; exp_rd1 = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_r0"}, 32'(req0_ready), 0);
        chk({tag, "_r1"}, 32'(req1_ready), 0);
        chk({tag, "_cs"}, 32'(mem_cs), 0);
        chk({tag, "_wr"}, 32'(mem_wr), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_din"}, 32'(mem_data_in), 0);
        chk({tag, "_rv0"}, 32'(rsp0_valid), 0);
        chk({tag, "_rv1"}, 32'(rsp1_valid), 0);
        chk({tag, "_rd0"}, 32'(rsp0_rdata), 0);
        chk({tag, "_rd1"}, 32'(rsp1_rdata), 0);
    endtask

    // Model: an accept at cycle t occupies the RAM at t+1 and responds at t+2; accesses apply in accept order
    task automatic sample();
        logic e_cs, e_rv, free, any, win;
        @(negedge clk);
        e_cs = (n == acc_at + 1);
        e_rv = (n == acc_at + 2);
        if (e_rv && !acc_wr) begin
            if (acc_port) exp_rd1 = acc_data;
            else exp_rd0 = acc_data;
        end
        free = (n >= acc_at + 2);
        any = req0_valid || req1_valid;
        win = (req0_valid && req1_valid) ? !last : req1_valid;
        m_acc0 = free && any && !win;
        m_acc1 = free && any && win;
        chk("req0_ready", 32'(req0_ready), 32'(m_acc0));
        chk("req1_ready", 32'(req1_ready), 32'(m_acc1));
        chk("mem_cs", 32'(mem_cs), 32'(e_cs));
        chk("mem_wr", 32'(mem_wr), 32'(e_cs && acc_wr));
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(last_wdata));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv && !acc_port));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv && acc_port));
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rd0));
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rd1));
        if (m_acc0 || m_acc1) begin
            acc_at = n; acc_port = win; last = win;
            acc_wr = win ? req1_wr : req0_wr;
            last_addr = win ? req1_addr : req0_addr;
            last_wdata = win ? req1_wdata : req0_wdata;
            if (acc_wr) ref_mem[last_addr] = last_wdata;
            acc_data = ref_mem[last_addr];
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        int dut_acc, consec, k;
        logic prev_wr;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
        //            v0 w0 a0       d0     v1 w1 a1       d1     r0 r1 cs wr rv0 rv1 chk rd0
        tbl[0]  = '{H, L, 10'h000, 8'h00, L, L, 10'h000, 8'h00, H, L, L, L, L, L, L, 8'h00};
        tbl[1]  = '{L, L, 10'h000, 8'h00, L, L, 10'h000, 8'h00, L, L, H, L, L, L, L, 8'h00};
        tbl[2]  = '{H, H, 10'h155, 8'h3A, L, L, 10'h000, 8'h00, H, L, L, L, H, L, H, 8'h00};
        tbl[3]  = '{L, L, 10'h000, 8'h00, L, L, 10'h000, 8'h00, L, L, H, H, L, L, L, 8'h00};
        tbl[4]  = '{H, L, 10'h155, 8'h00, L, L, 10'h000, 8'h00, H, L, L, L, H, L, L, 8'h00};
        tbl[5]  = '{L, L, 10'h000, 8'h00, L, L, 10'h000, 8'h00, L, L, H, L, L, L, L, 8'h00};
        tbl[6]  = '{H, L, 10'h010, 8'h00, H, L, 10'h020, 8'h00, L, H, L, L, H, L, H, 8'h3A};
        tbl[7]  = '{H, L, 10'h010, 8'h00, H, L, 10'h021, 8'h00, L, L, H, L, L, L, L, 8'h00};
        tbl[8]  = '{H, L, 10'h010, 8'h00, H, L, 10'h021, 8'h00, H, L, L, L, L, H, L, 8'h00};
        tbl[9]  = '{H, L, 10'h011, 8'h00, H, L, 10'h021, 8'h00, L, L, H, L, L, L, L, 8'h00};
        tbl[10] = '{H, L, 10'h011, 8'h00, H, L, 10'h021, 8'h00, L, H, L, L, H, L, H, 8'h10};
        tbl[11] = '{H, L, 10'h011, 8'h00, H, L, 10'h022, 8'h00, L, L, H, L, L, L, L, 8'h00};
        tbl[12] = '{H, L, 10'h011, 8'h00, H, L, 10'h022, 8'h00, H, L, L, L, L, H, L, 8'h00};

        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            sample();
            chk("tbl_r0", 32'(req0_ready), 32'(tbl[i].r0));
            chk("tbl_r1", 32'(req1_ready), 32'(tbl[i].r1));
            chk("tbl_cs", 32'(mem_cs), 32'(tbl[i].cs));
            chk("tbl_wr", 32'(mem_wr), 32'(tbl[i].wr));
            chk("tbl_rv0", 32'(rsp0_valid), 32'(tbl[i].rv0));
            chk("tbl_rv1", 32'(rsp1_valid), 32'(tbl[i].rv1));
            if (tbl[i].chk) chk("tbl_rd0", 32'(rsp0_rdata), 32'(tbl[i].rd0));
            advance();
        end

        // Cross-port coherency: port 0 was served last, so port 1's write goes first
        idle();
        step();
        drive(H, L, 10'h3FF, 8'h00, H, H, 10'h3FF, 8'hC5);
        sample();
        chk("coh_r1_first", 32'(req1_ready), 1);
        chk("coh_r0_waits", 32'(req0_ready), 0);
        advance();
        drive(H, L, 10'h3FF, 8'h00, L, L, '0, '0);
        step();
        step();
        idle();
        step();
        sample();
        chk("coh_rv0", 32'(rsp0_valid), 1);
        chk("coh_rd0", 32'(rsp0_rdata), 32'h0C5);
        advance();

        // Back-to-back writes from port 1
        dut_acc = 0; consec = 0; k = 0; prev_wr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (k < 6) drive(L, L, '0, '0, H, H, AW'(10'h100 + k), DW'(k * 17 + 1));
            else idle();
            sample();
            if (req1_ready) dut_acc++;
            if (mem_wr && prev_wr) consec++;
            prev_wr = mem_wr;
            advance();
            if (m_acc1) k++;
        end
        chk("b2b_accepts", 32'(dut_acc), 6);
        chk("b2b_wr_consecutive", 32'(consec), 0);
        idle();
        step();
        step();

        // Reset during the ACCESS cycle of a read
        drive(H, L, 10'h155, 8'h00, L, L, '0, '0);
        sample();
        advance();
        idle();
        chk("mid_cs_before", 32'(mem_cs), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_cs_async", 32'(mem_cs), 0);
        chk("mid_wr_async", 32'(mem_wr), 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("mid_no_rsp", 32'(rsp0_valid), 0);
        end
        rst_n = 1'b1;
        model_reset();
        drive(H, L, 10'h155, 8'h00, L, L, '0, '0);
        sample();
        chk("mid_idle_after", 32'(req0_ready), 1);
        advance();

        // Random traffic with small address range to force collisions and write/read ordering
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid || m_acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_wr = 1'($urandom_range(0, 1));
                req0_addr = AW'($urandom_range(0, 15));
                req0_wdata = DW'($urandom);
            end
            if (!req1_valid || m_acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_wr = 1'($urandom_range(0, 1));
                req1_addr = AW'($urandom_range(0, 15));
                req1_wdata = DW'($urandom);
            end
            step();
        end
        idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
